bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one dead turnaround cycle between owners.
// Optional forced release after MAX_HOLD grant cycles: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int N_REQ    = 32,
    parameter int SEL_W    = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] bus_sel,
    output logic             bus_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [SEL_W-1:0]   bus_sel_reg, bus_sel_next;
    logic [SEL_W-1:0]   last_ptr_reg, last_ptr_next;
    logic [N_REQ-1:0]   hi_mask;
    logic [N_REQ-1:0]   req_hi;
    logic [N_REQ-1:0]   win_onehot;
    logic [SEL_W-1:0]   win_idx;
    logic               win_found;
    logic               owner_req;
    logic               release_now;
    logic               exit_grant;

    if (N_REQ < 2 || N_REQ > 32 || SEL_W < $clog2(N_REQ) || MAX_HOLD < 2) begin : g_bad_params
        $error("bus_arbiter: illegal parameter combination");
    end

    // Requests strictly above the last owner take priority; otherwise wrap to the bottom.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hi_mask
        assign hi_mask[gi] = (SEL_W'(gi) > last_ptr_reg);
    end

    assign req_hi     = req & hi_mask;
    assign win_found  = |req;
    assign win_onehot = (|req_hi) ? (req_hi & (~req_hi + N_REQ'(1)))
                                  : (req & (~req + N_REQ'(1)));

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_onehot[i]) begin
                win_idx = win_idx | SEL_W'(i);
            end
        end
    end

    assign owner_req   = |(req & grant_reg);
    assign release_now = done || !owner_req;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              timeout_reg, timeout_next;
    logic              force_release;

    // A normal release on the same edge wins, so the pulse only marks true overruns.
    assign force_release = !release_now && (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
    assign exit_grant    = release_now || force_release;
`else
    assign exit_grant    = release_now;
`endif

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        bus_sel_next  = bus_sel_reg;
        last_ptr_next = last_ptr_reg;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;
`endif
        case (state_reg)
            GRANT: begin
                if (exit_grant) begin
                    state_next    = TURN;
                    grant_next    = '0;
                    last_ptr_next = bus_sel_reg;
`ifdef BUS_ARB_TIMEOUT_EN
                    timeout_next  = force_release;
`endif
                end else begin
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
`endif
                end
            end
            default: begin
                // IDLE and TURN arbitrate identically; bus_sel holds while nobody wins.
                if (win_found) begin
                    state_next   = GRANT;
                    grant_next   = win_onehot;
                    bus_sel_next = win_idx;
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_cnt_next = '0;
`endif
                end else begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            bus_sel_reg  <= '0;
            last_ptr_reg <= SEL_W'(N_REQ - 1);
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            bus_sel_reg  <= bus_sel_next;
            last_ptr_reg <= last_ptr_next;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
`endif
        end
    end

    assign grant     = grant_reg;
    assign bus_sel   = bus_sel_reg;
    assign bus_valid = |grant_reg;
`ifdef BUS_ARB_TIMEOUT_EN
    assign timeout   = timeout_reg;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter with a transaction-level reference model.
module tb_bus_arbiter;

    localparam int N_REQ    = 32;
    localparam int SEL_W    = 5;
    localparam int MAX_HOLD = 16;

    logic             clock;
    logic             clear_n;
    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] bus_sel;
    logic             bus_valid;
    logic             timeout;

    bus_arbiter #(.N_REQ(N_REQ), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .bus_sel  (bus_sel),
        .bus_valid(bus_valid),
        .timeout  (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [N_REQ-1:0] g;
        logic [SEL_W-1:0] s;
        logic             v;
        logic             t;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic mon_prev_v;

    int n_checks;
    int n_fail;

    // Reference model: who owns the bus, who owned it last, where the select points.
    int   m_owner;
    int   m_last;
    int   m_sel;
    int   m_hold;
    logic m_tmo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N_REQ - 1;
        m_sel   = 0;
        m_hold  = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step(input logic [N_REQ-1:0] r, input logic d);
        exp_t e;
        m_tmo = 1'b0;
        if (m_owner >= 0) begin
            bit rel;
            bit frc;
            rel = d || !r[m_owner];
            frc = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            frc = !rel && (m_hold == MAX_HOLD - 1);
`endif
            if (rel || frc) begin
                m_last  = m_owner;
                m_owner = -1;
                m_tmo   = frc;
            end else begin
                m_hold++;
            end
        end else begin
            for (int off = 1; off <= N_REQ; off++) begin
                int k;
                k = (m_last + off) % N_REQ;
                if (r[k]) begin
                    m_owner = k;
                    m_sel   = k;
                    m_hold  = 0;
                    break;
                end
            end
        end
        e.g = (m_owner >= 0) ? (N_REQ'(1) << m_owner) : '0;
        e.s = SEL_W'(m_sel);
        e.v = (m_owner >= 0);
        e.t = m_tmo;
        sb_q.push_back(e);
    endtask

    // Called right after a falling edge: drive, predict, then wait one full cycle.
    task automatic cycle(input logic [N_REQ-1:0] r, input logic d);
        req  = r;
        done = d;
        model_step(r, d);
        @(negedge clock);
    endtask

    task automatic do_reset(input logic expect_busy);
        @(posedge clock);
        #4;
        chk("pre_reset_valid", 32'(bus_valid), 32'(expect_busy));
        #1;
        clear_n = 1'b0;
        #1;
        chk("async_rst_grant", grant, '0);
        chk("async_rst_valid", 32'(bus_valid), 32'd0);
        chk("async_rst_sel", 32'(bus_sel), 32'd0);
        @(negedge clock);
        @(negedge clock);
        clear_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compares every cycle the DUT runs out of reset against the queued prediction.
    always @(posedge clock) begin
        #2;
        if (clear_n && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("grant", grant, mon_e.g);
            chk("bus_sel", 32'(bus_sel), 32'(mon_e.s));
            chk("bus_valid", 32'(bus_valid), 32'(mon_e.v));
            chk("timeout", 32'(timeout), 32'(mon_e.t));
            if (mon_e.v && !mon_prev_v)
                $display("txn: grant src %0d at %0t", mon_e.s, $time);
            if (mon_e.t)
                $display("txn: timeout release at %0t", $time);
            mon_prev_v = mon_e.v;
        end else begin
            mon_prev_v = 1'b0;
        end
    end

    initial begin
        logic [N_REQ-1:0] r;
        n_checks   = 0;
        n_fail     = 0;
        mon_prev_v = 1'b0;
        model_reset();
        clear_n = 1'b0;
        req     = '1;
        done    = 1'b0;

        // Reset state while requests are all high.
        #12;
        chk("rst_grant", grant, '0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_sel", 32'(bus_sel), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) cycle('1, (i % 3) == 2);

        // Single source 5 with a done pulse.
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) cycle(32'h0000_0020, 1'b0);
        cycle(32'h0000_0020, 1'b1);
        for (int i = 0; i < 3; i++) cycle(32'h0000_0000, 1'b0);

        // Round-robin over sources 0, 4, 8 with done one cycle into each grant.
        do_reset(1'b0);
        for (int i = 0; i < 14; i++) cycle(32'h0000_0111, m_owner >= 0);

        // Wrap from owner 31 to source 2, then back to 31.
        for (int i = 0; i < 3; i++) cycle(32'h8000_0000, 1'b0);
        cycle(32'h8000_0000, 1'b1);
        for (int i = 0; i < 3; i++) cycle(32'h8000_0004, 1'b0);
        cycle(32'h8000_0004, 1'b1);
        for (int i = 0; i < 3; i++) cycle(32'h8000_0004, 1'b0);
        cycle(32'h0000_0000, 1'b1);
        cycle(32'h0000_0000, 1'b0);

        // Long hold with no done: forced release only in the timeout build.
        do_reset(1'b0);
        for (int i = 0; i < 40; i++) cycle(32'h0000_0009, 1'b0);
        cycle(32'h0000_0000, 1'b0);
        cycle(32'h0000_0000, 1'b0);

        // Reset in the middle of source 7's grant, then source 0 must win.
        for (int i = 0; i < 4; i++) cycle(32'h0000_0080, 1'b0);
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) cycle(32'h0000_0081, 1'b0);

        // Random traffic with long request stretches so holds can run out.
        r = 32'h0000_0001;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       r = $urandom;
                    1:       r = $urandom & $urandom & $urandom;
                    2:       r = (N_REQ'(1) << $urandom_range(0, 31)) | (N_REQ'(1) << $urandom_range(0, 31));
                    default: r = '0;
                endcase
            end
            cycle(r, $urandom_range(0, 5) == 0);
        end

        @(posedge clock);
        #3;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
